// File: rtl/demux32_pkg.sv
// Shared defaults and port identifiers for the 1:2 word router.
package demux32_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned DEF_CNT_W = 16;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/demux32_fifo.sv
// Small synchronous FIFO for one router output port.
// Ports: clk, rst_n (async, active low); push/push_data write side;
// pop read side; full/empty/count status; head = oldest word, or the
// last popped word (0 after reset) while empty.
module demux32_fifo #(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_FW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [WIDTH-1:0]  head,
    output logic [CNT_FW-1:0] count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_FW-1:0] cnt_q;
    logic [WIDTH-1:0]  last_q;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents are never observed while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers (wrap mod DEPTH via natural overflow), occupancy, last popped word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_FW'(1);
                2'b01:   cnt_q <= cnt_q - CNT_FW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign full  = (cnt_q == CNT_FW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    // While empty the port keeps presenting the last word it handed out.
    assign head  = empty ? last_q : mem[rd_ptr];

endmodule

// File: rtl/demux32_router.sv
// 1:2 word router: one valid/ready input stream steered by select into one
// of two independent output FIFOs, each with a wrapping handshake counter.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data/select
// producer side; outN_valid/outN_ready/outN_data consumer sides;
// cnt0/cnt1 completed output handshakes per port.
module demux32_router
    import demux32_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             select,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam int unsigned CNT_FW = $clog2(DEPTH + 1);

    logic              full0, full1, empty0, empty1;
    logic [CNT_FW-1:0] count0, count1;
    logic              accept, push0, push1, pop0, pop1;
    logic [CNT_W-1:0]  cnt0_q, cnt1_q;
    logic              unused_status;

    // Ready depends only on registered occupancy of the selected port.
    assign in_ready = rst_n && !((select == PORT1) ? full1 : full0);
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (select == PORT0);
    assign push1    = accept && (select == PORT1);

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign pop0       = out0_valid && out0_ready;
    assign pop1       = out1_valid && out1_ready;

    demux32_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (in_data),
        .pop       (pop0),
        .full      (full0),
        .empty     (empty0),
        .head      (out0_data),
        .count     (count0)
    );

    demux32_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (in_data),
        .pop       (pop1),
        .full      (full1),
        .empty     (empty1),
        .head      (out1_data),
        .count     (count1)
    );

    // Occupancy is carried by full/empty here; raw counts are not needed.
    assign unused_status = &{1'b0, count0, count1};

    // Per-port handshake counters, free-running with wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (pop0) begin
                cnt0_q <= cnt0_q + CNT_W'(1);
            end
            if (pop1) begin
                cnt1_q <= cnt1_q + CNT_W'(1);
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;

endmodule

// File: tb/tb_demux32_router.sv
// Bench for demux32_router: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_demux32_router;

    localparam int unsigned W      = 32;
    localparam int unsigned D      = 2;
    localparam int unsigned CW     = 4;
    localparam int unsigned CMOD   = 1 << CW;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          select;
    logic          out0_valid, out1_valid;
    logic          out0_ready, out1_ready;
    logic [W-1:0]  out0_data, out1_data;
    logic [CW-1:0] cnt0, cnt1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    demux32_router #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .select     (select),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-port queues of words, last handed-out word, counts.
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;
    int unsigned  mcnt0 = 0;
    int unsigned  mcnt1 = 0;

    always @(posedge clk or negedge rst_n) begin : model
        automatic bit p0 = (q0.size() != 0) && out0_ready;
        automatic bit p1 = (q1.size() != 0) && out1_ready;
        automatic bit a0 = in_valid && (select == 1'b0) && (q0.size() < D);
        automatic bit a1 = in_valid && (select == 1'b1) && (q1.size() < D);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last0 <= '0;
            last1 <= '0;
            mcnt0 <= 0;
            mcnt1 <= 0;
        end else begin
            if (p0) begin
                last0 <= q0.pop_front();
                mcnt0 <= (mcnt0 + 1) % CMOD;
            end
            if (p1) begin
                last1 <= q1.pop_front();
                mcnt1 <= (mcnt1 + 1) % CMOD;
            end
            if (a0) q0.push_back(in_data);
            if (a1) q1.push_back(in_data);
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",   32'(in_ready),
                  32'(rst_n && (((select ? q1.size() : q0.size())) < D)));
            check("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
            check("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
            check("out0_data",  out0_data, (q0.size() != 0) ? q0[0] : last0);
            check("out1_data",  out1_data, (q1.size() != 0) ? q1[0] : last1);
            check("cnt0",       32'(cnt0), mcnt0);
            check("cnt1",       32'(cnt1), mcnt1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic s);
        in_valid = v;
        in_data  = d;
        select   = s;
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        select     = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        #2 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        chk_en = 1;

        // 1: idle after reset
        tick();
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_v0", 32'(out0_valid), 32'd0);
        check("t1_v1", 32'(out1_valid), 32'd0);
        check("t1_cnt0", 32'(cnt0), 32'd0);
        check("t1_cnt1", 32'(cnt1), 32'd0);
        check("t1_d0", out0_data, 32'd0);
        check("t1_d1", out1_data, 32'd0);

        // 2: routing
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 1'b0);
        tick();
        check("t2_v0", 32'(out0_valid), 32'd1);
        check("t2_d0", out0_data, 32'hDEADBEEF);
        drive(1'b1, 32'h12345678, 1'b1);
        tick();
        check("t2_v1", 32'(out1_valid), 32'd1);
        check("t2_d1", out1_data, 32'h12345678);
        check("t2_cnt0", 32'(cnt0), 32'd1);
        check("t2_d0_hold", out0_data, 32'hDEADBEEF);
        drive(1'b0, '0, 1'b0);
        tick();
        check("t2_cnt1", 32'(cnt1), 32'd1);

        // 3: backpressure on port 0, port 1 unaffected
        out0_ready = 1'b0;
        drive(1'b1, 32'h1, 1'b0);
        tick();
        in_data = 32'h2;
        tick();
        in_data = 32'h3;
        #1;
        check("t3_full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'hA, 1'b1);
        #1;
        check("t3_port1_ready", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 32'h3, 1'b0);
        #1;
        check("t3_still_full", 32'(in_ready), 32'd0);
        check("t3_head1", out0_data, 32'h1);
        out0_ready = 1'b1;
        #1;
        check("t3_no_ready_path", 32'(in_ready), 32'd0);
        tick();
        check("t3_head2", out0_data, 32'h2);
        check("t3_ready_again", 32'(in_ready), 32'd1);
        tick();
        check("t3_head3", out0_data, 32'h3);
        drive(1'b0, '0, 1'b0);
        tick();
        check("t3_cnt0", 32'(cnt0), 32'd4);
        check("t3_cnt1", 32'(cnt1), 32'd2);

        // 4: push/pop same cycle on port 1 at count 1
        out1_ready = 1'b0;
        drive(1'b1, 32'h10, 1'b1);
        tick();
        check("t4_head10", out1_data, 32'h10);
        in_data    = 32'h11;
        out1_ready = 1'b1;
        tick();
        check("t4_model_depth", 32'(q1.size()), 32'd1);
        check("t4_head11", out1_data, 32'h11);
        drive(1'b0, '0, 1'b0);
        tick();
        check("t4_empty", 32'(out1_valid), 32'd0);
        check("t4_hold", out1_data, 32'h11);
        check("t4_cnt1", 32'(cnt1), 32'd4);

        // 5: counter wrap after 17 handshakes from zero
        rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        out0_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(1'b1, 32'(k + 100), 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0);
        tick();
        check("t5_wrap", 32'(cnt0), 32'd1);
        check("t5_last", out0_data, 32'd116);

        // 6: async reset mid-burst
        out0_ready = 1'b0;
        drive(1'b1, 32'hAA, 1'b0);
        tick();
        in_data = 32'hBB;
        tick();
        drive(1'b0, '0, 1'b0);
        check("t6_model_depth", 32'(q0.size()), 32'd2);
        check("t6_head", out0_data, 32'hAA);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_v0", 32'(out0_valid), 32'd0);
        check("t6_async_d0", out0_data, 32'd0);
        check("t6_async_cnt0", 32'(cnt0), 32'd0);
        check("t6_async_ready", 32'(in_ready), 32'd0);
        tick();
        check("t6_hold_v0", 32'(out0_valid), 32'd0);
        #2 rst_n = 1'b1;
        out0_ready = 1'b1;
        tick();
        tick();
        check("t6_no_stale_v", 32'(out0_valid), 32'd0);
        check("t6_no_stale_d", out0_data, 32'd0);
        check("t6_cnt0", 32'(cnt0), 32'd0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
